mandelbrot_iter_ctrl: RTL and testbench

- Per-pixel iteration sequencer that sits directly upstream of the Mandelbrot ALU.
- Accepts a pixel coordinate (cr, ci) over a valid/ready handshake and drives the ALU's start, first_iteration, c and z operands.
- Feeds each ALU result back as the next z, detects escape (size or overflow), and counts iterations.
- Emits the iteration count over a valid/ready handshake to the colour/pixel output stage.

---
 rtl/mandelbrot_pkg.sv | 19 +
 rtl/mandelbrot_iter_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mandelbrot_iter_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel pipeline.
//   state_e      : iteration sequencer FSM encoding
//   DefWidth     : default coordinate / z width, fixed point 2.(WIDTH-2)
//   DefIterWidth : default iteration counter width
//   One          : fixed-point 1.0 at the default width
package mandelbrot_pkg;

  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefIterWidth = 6;
  localparam int unsigned One          = 1 << (DefWidth - 2);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/mandelbrot_iter_ctrl.sv
// Per-pixel iteration sequencer placed directly upstream of the Mandelbrot ALU.
// It accepts one pixel coordinate at a time, runs z <= z^2 + c on the ALU until
// escape or the iteration limit, then presents the iteration count downstream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   max_iter            iteration limit, sampled on pixel accept
//   px_valid/px_ready   pixel handshake; px_cr/px_ci signed coordinate
//   alu_start           one-cycle ALU start pulse
//   alu_first_iteration high while the first ALU operation of a pixel runs
//   alu_cr/ci/zr/zi     registered ALU operands
//   alu_finished        ALU result strobe with alu_out_zr/zi, alu_size, alu_overflow
//   res_valid/res_ready result handshake; res_iter count, res_escaped divergence flag
//
// Optional build macro MANDELBROT_ITER_CYCLES_EN adds res_cycles: clock cycles
// from pixel accept to res_valid rise, saturating at 16'hFFFF.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned ITER_WIDTH = DefIterWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [WIDTH-1:0]      px_cr,
  input  logic [WIDTH-1:0]      px_ci,
  output logic                  alu_start,
  output logic                  alu_first_iteration,
  input  logic                  alu_finished,
  output logic [WIDTH-1:0]      alu_cr,
  output logic [WIDTH-1:0]      alu_ci,
  output logic [WIDTH-1:0]      alu_zr,
  output logic [WIDTH-1:0]      alu_zi,
  input  logic [WIDTH-1:0]      alu_out_zr,
  input  logic [WIDTH-1:0]      alu_out_zi,
  input  logic                  alu_size,
  input  logic                  alu_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ITER_WIDTH-1:0] res_iter,
  output logic                  res_escaped
`ifdef MANDELBROT_ITER_CYCLES_EN
  ,
  output logic [15:0]           res_cycles
`endif
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      cr_q, cr_d, ci_q, ci_d;
  logic [WIDTH-1:0]      zr_q, zr_d, zi_q, zi_d;
  logic [ITER_WIDTH-1:0] n_q, n_d, max_q, max_d;
  logic [ITER_WIDTH-1:0] res_iter_q, res_iter_d;
  logic                  res_escaped_q, res_escaped_d;
  logic [ITER_WIDTH-1:0] n_inc;

  assign n_inc = n_q + ITER_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    cr_d          = cr_q;
    ci_d          = ci_q;
    zr_d          = zr_q;
    zi_d          = zi_q;
    n_d           = n_q;
    max_d         = max_q;
    res_iter_d    = res_iter_q;
    res_escaped_d = res_escaped_q;
    unique case (state_q)
      StIdle: begin
        if (px_valid) begin
          cr_d  = px_cr;
          ci_d  = px_ci;
          max_d = max_iter;
          zr_d  = '0;
          zi_d  = '0;
          n_d   = '0;
          if (max_iter == '0) begin
            // Zero limit: report immediately, the ALU is never started.
            res_iter_d    = '0;
            res_escaped_d = 1'b0;
            state_d       = StDone;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (alu_finished) begin
          if (alu_size || alu_overflow) begin
            // Size flag belongs to the z just squared, so n is the escape index.
            res_iter_d    = n_q;
            res_escaped_d = 1'b1;
            state_d       = StDone;
          end else begin
            zr_d = alu_out_zr;
            zi_d = alu_out_zi;
            n_d  = n_inc;
            if (n_inc == max_q) begin
              res_iter_d    = max_q;
              res_escaped_d = 1'b0;
              state_d       = StDone;
            end else begin
              state_d = StStart;
            end
          end
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cr_q          <= '0;
      ci_q          <= '0;
      zr_q          <= '0;
      zi_q          <= '0;
      n_q           <= '0;
      max_q         <= '0;
      res_iter_q    <= '0;
      res_escaped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cr_q          <= cr_d;
      ci_q          <= ci_d;
      zr_q          <= zr_d;
      zi_q          <= zi_d;
      n_q           <= n_d;
      max_q         <= max_d;
      res_iter_q    <= res_iter_d;
      res_escaped_q <= res_escaped_d;
    end
  end

  assign px_ready            = (state_q == StIdle);
  assign alu_start           = (state_q == StStart);
  assign alu_first_iteration = ((state_q == StStart) || (state_q == StWait)) && (n_q == '0);
  assign alu_cr              = cr_q;
  assign alu_ci              = ci_q;
  assign alu_zr              = zr_q;
  assign alu_zi              = zi_q;
  assign res_valid           = (state_q == StDone);
  assign res_iter            = res_iter_q;
  assign res_escaped         = res_escaped_q;

`ifdef MANDELBROT_ITER_CYCLES_EN
  logic [15:0] cyc_q, cyc_d;

  // Accept edge counts as cycle 1; every START/WAIT edge adds one, including
  // the edge that enters DONE, so the value freezes at res_valid rise.
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == StIdle) && px_valid) begin
      cyc_d = 16'd1;
    end else if (((state_q == StStart) || (state_q == StWait)) && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign res_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
module tb_mandelbrot_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] max_iter;
  logic       px_valid;
  logic       px_ready;
  logic [7:0] px_cr, px_ci;
  logic       alu_start, alu_first_iteration, alu_finished;
  logic [7:0] alu_cr, alu_ci, alu_zr, alu_zi;
  logic [7:0] alu_out_zr, alu_out_zi;
  logic       alu_size, alu_overflow;
  logic       res_valid, res_ready;
  logic [5:0] res_iter;
  logic       res_escaped;

  int n_checks = 0;
  int n_fail   = 0;

  mandelbrot_iter_ctrl #(.WIDTH(8), .ITER_WIDTH(6)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .max_iter            (max_iter),
    .px_valid            (px_valid),
    .px_ready            (px_ready),
    .px_cr               (px_cr),
    .px_ci               (px_ci),
    .alu_start           (alu_start),
    .alu_first_iteration (alu_first_iteration),
    .alu_finished        (alu_finished),
    .alu_cr              (alu_cr),
    .alu_ci              (alu_ci),
    .alu_zr              (alu_zr),
    .alu_zi              (alu_zi),
    .alu_out_zr          (alu_out_zr),
    .alu_out_zi          (alu_out_zi),
    .alu_size            (alu_size),
    .alu_overflow        (alu_overflow),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_iter            (res_iter),
    .res_escaped         (res_escaped)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Fixed-point 2.6 step: returns {size, overflow, next_zr[7:0], next_zi[7:0]}.
  function automatic logic [17:0] alu_math(input int zr, input int zi, input int cr, input int ci);
    int sq_r, sq_i, nr, ni;
    logic sz, ov;
    sq_r = zr * zr;
    sq_i = zi * zi;
    nr   = ((sq_r - sq_i) >>> 6) + cr;
    ni   = ((2 * zr * zi) >>> 6) + ci;
    sz   = (sq_r + sq_i) > 16384;
    ov   = (nr > 127) || (nr < -128) || (ni > 127) || (ni < -128);
    return {sz, ov, nr[7:0], ni[7:0]};
  endfunction

  // Whole-pixel reference: iterate until escape or the limit.
  function automatic void ref_pixel(input int cr, input int ci, input int mx,
                                    output int it, output bit esc);
    logic [17:0] r;
    int zr, zi;
    zr  = 0;
    zi  = 0;
    it  = mx;
    esc = 1'b0;
    for (int k = 0; k < mx; k++) begin
      r = alu_math(zr, zi, cr, ci);
      if (r[17] || r[16]) begin
        it  = k;
        esc = 1'b1;
        return;
      end
      zr = int'($signed(r[15:8]));
      zi = int'($signed(r[7:0]));
    end
  endfunction

  // Behavioural ALU: result 3 cycles after start; random stray strobes while idle.
  int          lat;
  logic [17:0] pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat          <= 0;
      pend         <= '0;
      alu_finished <= 1'b0;
      alu_size     <= 1'b0;
      alu_overflow <= 1'b0;
      alu_out_zr   <= '0;
      alu_out_zi   <= '0;
    end else begin
      alu_finished <= 1'b0;
      if (alu_start) begin
        lat  <= 3;
        pend <= alu_math(int'($signed(alu_zr)), int'($signed(alu_zi)),
                         int'($signed(alu_cr)), int'($signed(alu_ci)));
      end else if (lat == 1) begin
        lat          <= 0;
        alu_finished <= 1'b1;
        alu_size     <= pend[17];
        alu_overflow <= pend[16];
        alu_out_zr   <= pend[15:8];
        alu_out_zi   <= pend[7:0];
      end else if (lat > 1) begin
        lat <= lat - 1;
      end else if ($urandom_range(7) == 0) begin
        alu_finished <= 1'b1;
        alu_size     <= 1'b1;
        alu_overflow <= 1'($urandom);
        alu_out_zr   <= 8'($urandom);
        alu_out_zi   <= 8'($urandom);
      end
    end
  end

  // Compare process: model state describes what the outputs must be this cycle,
  // then advances using the inputs that the next rising edge will sample.
  bit busy, res_m, outstanding, prev_start;
  int cur_cr, cur_ci, cur_max, ops, starts, ez_r, ez_i, ref_it, exp_starts;
  bit ref_esc;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_px_ready", int'(px_ready), 1);
      chk("rst_alu_start", int'(alu_start), 0);
      chk("rst_first_iter", int'(alu_first_iteration), 0);
      chk("rst_operands", int'({alu_cr, alu_ci, alu_zr, alu_zi}), 0);
      chk("rst_res", int'({res_valid, res_iter, res_escaped}), 0);
      busy = 0; res_m = 0; outstanding = 0; prev_start = 0;
    end else begin
      chk("px_ready", int'(px_ready), int'(!busy));
      chk("res_valid", int'(res_valid), int'(res_m));
      if (res_m) begin
        chk("res_iter", int'(res_iter), ref_it);
        chk("res_escaped", int'(res_escaped), int'(ref_esc));
      end
      if (busy && !res_m) begin
        chk("alu_cr", int'($signed(alu_cr)), cur_cr);
        chk("alu_ci", int'($signed(alu_ci)), cur_ci);
        chk("alu_zr", int'($signed(alu_zr)), ez_r);
        chk("alu_zi", int'($signed(alu_zi)), ez_i);
      end
      if (alu_start) begin
        chk("start_legal", int'(busy && !res_m && !outstanding && !prev_start), 1);
        chk("first_iter", int'(alu_first_iteration), int'(starts == 0));
      end else if (!busy || res_m) begin
        chk("first_iter_idle", int'(alu_first_iteration), 0);
      end
      prev_start = alu_start;
      if (alu_finished && outstanding) begin
        outstanding = 0;
        if (alu_size || alu_overflow) begin
          res_m = 1;
        end else begin
          ez_r = int'($signed(alu_out_zr));
          ez_i = int'($signed(alu_out_zi));
          ops++;
          if (ops == cur_max) res_m = 1;
        end
        if (res_m) chk("alu_starts", starts, exp_starts);
      end
      if (alu_start) begin
        outstanding = 1;
        starts++;
      end
      if (res_valid && res_ready && res_m) begin
        busy  = 0;
        res_m = 0;
      end
      if (px_valid && px_ready && !busy) begin
        busy    = 1;
        cur_cr  = int'($signed(px_cr));
        cur_ci  = int'($signed(px_ci));
        cur_max = int'(max_iter);
        ez_r = 0; ez_i = 0; ops = 0; starts = 0;
        ref_pixel(cur_cr, cur_ci, cur_max, ref_it, ref_esc);
        exp_starts = ref_esc ? ref_it + 1 : ref_it;
        if (cur_max == 0) res_m = 1;
      end
    end
  end

  task automatic run_pixel(input int cr, input int ci, input int mx, input int stall,
                           output int it, output bit esc, output int lat_cyc);
    int cnt;
    cnt = 0;
    while (!px_ready && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    chk("px_ready_timeout", int'(px_ready), 1);
    px_cr    = cr[7:0];
    px_ci    = ci[7:0];
    max_iter = mx[5:0];
    px_valid = 1'b1;
    @(posedge clk); #1;
    px_valid = 1'b0;
    px_cr    = 8'($urandom);
    px_ci    = 8'($urandom);
    max_iter = 6'($urandom);
    cnt = 1;
    while (!res_valid && cnt < 5000) begin
      @(posedge clk); #1; cnt++;
    end
    chk("res_timeout", int'(res_valid), 1);
    lat_cyc = cnt;
    it      = int'(res_iter);
    esc     = res_escaped;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("px_ready_after", int'(px_ready), 1);
  endtask

  initial begin
    int it, lc, cnt;
    bit esc;
    rst_n = 1'b0; px_valid = 1'b0; res_ready = 1'b0;
    px_cr = '0; px_ci = '0; max_iter = '0;

    // Pin the reference model with hand-derived results.
    ref_pixel(0, 0, 15, it, esc);    chk("model_c0", it * 2 + int'(esc), 30);
    ref_pixel(96, 96, 15, it, esc);  chk("model_c96", it * 2 + int'(esc), 3);
    ref_pixel(5, -7, 0, it, esc);    chk("model_max0", it * 2 + int'(esc), 0);
    ref_pixel(-128, 0, 10, it, esc); chk("model_m2_esc", int'(esc), 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_pixel(0, 0, 15, 0, it, esc, lc);
    chk("c0_iter", it, 15);
    chk("c0_esc", int'(esc), 0);
    run_pixel(96, 96, 15, 1, it, esc, lc);
    chk("c96_iter", it, 1);
    chk("c96_esc", int'(esc), 1);
    run_pixel(-37, 100, 0, 0, it, esc, lc);
    chk("max0_iter", it, 0);
    chk("max0_esc", int'(esc), 0);
    chk("max0_latency_ok", int'(lc <= 2), 1);
    run_pixel(-128, 0, 10, 2, it, esc, lc);
    chk("m2_esc", int'(esc), 1);
    run_pixel(20, -30, 12, 20, it, esc, lc);

    // Reset mid-iteration.
    px_cr = 8'd0; px_ci = 8'd0; max_iter = 6'd63; px_valid = 1'b1;
    @(posedge clk); #1;
    px_valid = 1'b0;
    cnt = 0;
    while (!alu_start && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("rst_run_started", int'(alu_start), 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("async_px_ready", int'(px_ready), 1);
    chk("async_alu_start", int'(alu_start), 0);
    chk("async_outputs", int'({alu_first_iteration, res_valid, res_iter, res_escaped}), 0);
    chk("async_operands", int'({alu_cr, alu_ci, alu_zr, alu_zi}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_pixel(96, 96, 15, 0, it, esc, lc);
    chk("post_rst_iter", it, 1);
    chk("post_rst_esc", int'(esc), 1);

    for (int i = 0; i < 30; i++) begin
      int rcr, rci, rmx;
      rcr = int'($urandom_range(255)) - 128;
      rci = int'($urandom_range(255)) - 128;
      rmx = (i % 10 == 9) ? 63 : int'($urandom_range(20));
      if (i % 7 == 3) begin
        rcr = int'($urandom_range(40)) - 20;
        rci = int'($urandom_range(40)) - 20;
      end
      run_pixel(rcr, rci, rmx, int'($urandom_range(3)), it, esc, lc);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
